// File: rtl/mac_pkg.sv
// mac_pkg: widths, FSM states and result saturation shared by the MAC engine.
package mac_pkg;
  localparam int N_A = 36;
  localparam int N_X = 18;
  localparam int N_Y = 18;
  localparam int N_I = 6;
  localparam int FRAC_A = 18;
  localparam int N_ACC = 60;
  typedef enum logic {IDLE, RUN} state_t;
  // Rescale by the coefficient's fractional bits, then clamp to the signed N_Y range.
  function automatic logic signed [N_Y-1:0] sat_y(input logic signed [N_ACC-1:0] v);
    logic signed [N_ACC-1:0] s;
    s = v >>> FRAC_A;
    return (&s[N_ACC-1:N_Y-1] | ~|s[N_ACC-1:N_Y-1]) ? s[N_Y-1:0] : {s[N_ACC-1], {(N_Y-1){~s[N_ACC-1]}}};
  endfunction
endpackage

// File: rtl/mac_datapath.sv
// mac_datapath: signed multiplier, accumulator and saturated result register.
module mac_datapath
  import mac_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  acc_en,
  input  logic                  fin,
  input  logic signed [N_A-1:0] a,
  input  logic signed [N_X-1:0] x,
  output logic signed [N_Y-1:0] y
);
  logic signed [N_A+N_X-1:0] prod;
  logic signed [N_ACC-1:0] acc, acc_next;
  assign prod = a * x;
  assign acc_next = acc + N_ACC'(prod);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc <= '0;
      y <= '0;
    end else begin
      acc <= clr ? '0 : acc_en ? acc_next : acc;
      y <= fin ? sat_y(acc_next) : y;
    end
endmodule

// File: rtl/mac_top.sv
// mac_top: sequential MAC over ROM indices start_idx..end_idx, one term per clock.
module mac_top
  import mac_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stf,
  input  logic signed [N_X-1:0] x,
  input  logic signed [N_A-1:0] a,
  input  logic [N_I-1:0]        start_idx,
  input  logic [N_I-1:0]        end_idx,
  output logic                  eof,
  output logic [N_I-1:0]        i,
  output logic signed [N_Y-1:0] y
);
  state_t state, state_n;
  logic stf_d, start, last, acc_en;
  logic [N_I-1:0] i_n;
  // Only a fresh rising edge of stf in IDLE launches a run.
  always_comb begin
    start = state == IDLE && stf && !stf_d;
    last = state == RUN && i == end_idx;
    acc_en = state == RUN && !last;
    state_n = start ? RUN : last ? IDLE : state;
    i_n = start ? start_idx : acc_en ? i + 1'b1 : i;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      i <= '0;
      eof <= 1'b0;
      stf_d <= 1'b0;
    end else begin
      state <= state_n;
      i <= i_n;
      eof <= last;
      stf_d <= stf;
    end
  mac_datapath u_dp (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .acc_en(acc_en),
    .fin(last),
    .a(a),
    .x(x),
    .y(y)
  );
endmodule

// File: tb/tb_mac_top.sv
// tb_mac_top: randomized and directed runs against a summation model, scoreboarded on eof.
module tb_mac_top;
  import mac_pkg::*;
  typedef struct {
    logic signed [N_Y-1:0] y;
    int cyc;
  } exp_t;
  logic clk = 0, rst = 0, stf = 0;
  logic [N_I-1:0] start_idx = '0, end_idx = '0, i;
  logic signed [N_A-1:0] a;
  logic signed [N_X-1:0] x;
  logic signed [N_Y-1:0] y;
  logic eof;
  logic signed [N_A-1:0] rom_a[64];
  logic signed [N_X-1:0] rom_x[64];
  int checks = 0, errors = 0, cyc = 0, eof_cnt = 0, c0;
  exp_t q[$];
  exp_t m_e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign a = rom_a[i];
  assign x = rom_x[i];
  mac_top dut (
    .clk(clk),
    .rst(rst),
    .stf(stf),
    .x(x),
    .a(a),
    .start_idx(start_idx),
    .end_idx(end_idx),
    .eof(eof),
    .i(i),
    .y(y)
  );
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (rst && eof) begin
      eof_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_eof: got eof=1 y=%0d, required no eof", y);
      end else begin
        m_e = q.pop_front();
        chk("y", y, m_e.y);
        chk("eof_time", cyc, m_e.cyc);
      end
    end
  function automatic longint model(input int s, input int e);
    longint sum = 0, r;
    int n = ((e - s) & 63) + 1;
    for (int k = 0; k < n; k++) sum += longint'(rom_a[(s + k) & 63]) * longint'(rom_x[(s + k) & 63]);
    r = sum >>> FRAC_A;
    return r > 131071 ? 131071 : r < -131072 ? -131072 : r;
  endfunction
  task automatic fill(input longint av, input int xm, input int xc);
    for (int k = 0; k < 64; k++) begin
      rom_a[k] = N_A'(av);
      rom_x[k] = N_X'(xm * k + xc);
    end
  endtask
  task automatic run(input int s, input int e, input bit hold);
    int n;
    logic signed [N_Y-1:0] y0;
    exp_t ex;
    n = ((e - s) & 63) + 1;
    start_idx = N_I'(s);
    end_idx = N_I'(e);
    stf = 0;
    @(negedge clk);
    @(negedge clk);
    stf = 1;
    y0 = y;
    @(posedge clk);
    #1;
    ex.y = N_Y'(model(s, e));
    ex.cyc = cyc + n;
    q.push_back(ex);
    for (int k = 0; k < n; k++) begin
      chk("i_seq", i, (s + k) & 63);
      chk("y_hold", y, y0);
      chk("eof_low", eof, 0);
      @(posedge clk);
      #1;
    end
    chk("eof_rise", eof, 1);
    @(posedge clk);
    #1;
    chk("eof_pulse", eof, 0);
    chk("i_hold", i, e);
    chk("pending", q.size(), 0);
    if (!hold) stf = 0;
  endtask
  initial begin
    int n0;
    fill(1 << 18, 1, 0);
    #12;
    chk("rst_i", i, 0);
    chk("rst_y", y, 0);
    chk("rst_eof", eof, 0);
    #8 rst = 1;
    run(2, 28, 0);
    fill(1 << 18, -1, 0);
    run(2, 28, 0);
    fill((64'd1 << 35) - 1, 0, 131071);
    run(2, 28, 0);
    fill((64'd1 << 35) - 1, 0, -131072);
    run(2, 28, 0);
    fill(1 << 18, 1, 0);
    run(5, 5, 0);
    run(62, 1, 0);
    n0 = eof_cnt;
    run(2, 28, 1);
    repeat (40) @(posedge clk);
    #1;
    chk("held_stf_runs", eof_cnt - n0, 1);
    run(2, 28, 0);
    @(negedge clk);
    stf = 1;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("abort_i", i, 0);
    chk("abort_y", y, 0);
    chk("abort_eof", eof, 0);
    stf = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    run(2, 28, 0);
    repeat (8) begin
      for (int k = 0; k < 64; k++) begin
        rom_a[k] = ($urandom_range(0, 1) != 0) ? N_A'({$urandom, $urandom}) : N_A'($signed($urandom_range(0, 1 << 22)) - (1 << 21));
        rom_x[k] = N_X'($urandom);
      end
      run(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 0);
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_top.md
Name: mac_top

Overview:
- Sequential multiply-accumulate engine. Computes y = Σ a[k]·x[k] for k = start_idx … end_idx, one term per clock.
- Coefficients a and samples x come from two external combinational ROMs (coefficient ROM, sample ROM). Both ROMs are addressed by this block's i output.
- Result appears on y with a one-cycle eof pulse. Sits between the coefficient/sample ROMs and the downstream consumer of the filtered value.

Parameters:
- N_A, 36, coefficient width (signed)
- N_X, 18, sample width (signed)
- N_Y, 18, result width (signed)
- N_I, 6, ROM address width
- FRAC_A, 18, fractional bits of a; product is scaled back by this shift
- N_ACC, 60, accumulator width (N_A+N_X+N_I, no internal overflow for 64 terms)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- stf  in  1  start request (level input, rising edge acted on)
- x  in  N_X  sample from sample ROM at address i (combinational, same cycle)
- a  in  N_A  coefficient from coefficient ROM at address i (combinational, same cycle)
- start_idx  in  N_I  first index (static during a run)
- end_idx  in  N_I  last index (static during a run)
- eof  out  1  one-cycle pulse: y updated with a new result
- i  out  N_I  ROM read address
- y  out  N_Y  signed result, saturated

Behaviour:
- Reset (rst=0, async): state=IDLE, i=0, acc=0, y=0, eof=0, stf_d=0.
- stf_d is stf registered each cycle. Start condition: stf=1 and stf_d=0, evaluated only in IDLE. Holding stf high does not restart. stf while RUN is ignored.
- States: IDLE, RUN.
- IDLE, start condition at edge E0: i←start_idx, acc←0, state←RUN.
- RUN, each edge: prod = $signed(a)·$signed(x), full 54-bit; acc_next = acc + sign-extended prod.
  - If i != end_idx: acc←acc_next, i←i+1 (wraps 63→0).
  - If i == end_idx: y←sat(acc_next >>> FRAC_A), arithmetic shift, truncation toward −∞. Also eof←1, state←IDLE, i holds.
- sat: clamp to [−2^(N_Y−1), 2^(N_Y−1)−1] = [−131072, 131071].
- eof is registered and high for exactly one cycle after the final edge; otherwise 0.
- Latency: N = ((end_idx − start_idx) mod 64) + 1 terms. eof rises at edge E_N after E0.
  - start=2, end=28 gives 27 terms; eof at E27.
- start_idx == end_idx: single term, eof at E1.
- end_idx < start_idx: address wraps through 63 to 0 and stops at end_idx.
- y holds its value between runs. It is not cleared at start.
- Reset mid-run aborts immediately to reset values. There is no partial result.

Decomposition:
- Package mac_pkg holds:
  - width constants N_A, N_X, N_Y, N_I, FRAC_A, N_ACC
  - state enum {IDLE, RUN}
  - saturation function sat_y
- One sub-module, mac_datapath: multiplier, accumulator register, shift + saturation. Controlled by clear/accumulate enables from the FSM in mac_top.
- The ROMs stay outside the block.

Test Plan:
- All cases use stub ROMs with a[k]=2^18 (1.0) and x[k]=k, start_idx=2, end_idx=28, rst low 20 ns, stf pulse.
- Basic run: pulse stf → y=405, eof high exactly 1 cycle, 27 cycles after start edge; i sequence 2…28.
- Negative: x[k]=−k → y=−405. Saturation: a[k]=2^35−1, x[k]=131071 → y=131071. With x[k]=−131072 → y=−131072.
- Single term, start=end=5 → y=5, eof at E1. Wrap, start=62, end=1 → i = 62, 63, 0, 1; y=126.
- stf held high for 40 cycles → exactly one run and one eof. A second rising stf after eof → new run, same y, and y keeps its old value until the new eof.
- Reset asserted at cycle 10 of a run → i=0, y=0, eof=0 immediately. A fresh start after release gives the correct full result.
